// File: rtl/cmd_sequencer.sv
// Scripted command replayer for RemoteComm: buffers 16-bit commands, issues them
// one at a time, waits for cmd_sent and an ACK response under a watchdog, and reports the result.
module cmd_sequencer #(
  parameter int          DEPTH   = 16,
  parameter int          TMO_W   = 24,
  parameter int          TIMEOUT = 10_000_000,
  parameter logic [7:0]  ACK     = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic [15:0]                load_cmd,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       clr,
  output logic [15:0]                cmd,
  output logic                       send_cmd,
  input  logic                       cmd_sent,
  input  logic                       resp_rdy,
  input  logic [7:0]                 resp,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       tmo_err,
  output logic                       resp_err,
  output logic [$clog2(DEPTH)-1:0]   fail_idx,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_SENT, WAIT_RESP, FINISH} state_t;
  typedef enum logic [2:0] {RES_NONE, RES_PASS, RES_TMO, RES_RESP, RES_ABORT} result_t;

  state_t            state, state_next;
  result_t           result;
  logic [AW-1:0]     idx, idx_next;
  logic [TMO_W-1:0]  timer;
  logic [15:0]       mem [DEPTH];

  logic clr_go, start_go, load_go, tmo_hit, last_cmd;

  assign busy     = (state != IDLE);
  assign done     = (state == FINISH);
  assign send_cmd = (state == ISSUE);
  assign full     = (count == (AW+1)'(DEPTH));

  assign clr_go   = clr && !busy;
  assign start_go = start && !busy && !clr;
  assign load_go  = load && !busy && !full && !clr;
  // The terminal count is the TIMEOUT-th wait cycle after ISSUE; a same-cycle event still wins.
  assign tmo_hit  = (timer == TMO_LAST);
  assign last_cmd = ({1'b0, idx} == count - 1'b1);

  // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_next = state;
    idx_next   = idx;
    result     = RES_NONE;
    unique case (state)
      IDLE: begin
        if (start_go) begin
          if (count == '0) begin
            state_next = FINISH;
          end else begin
            state_next = ISSUE;
            idx_next   = '0;
          end
        end
      end
      ISSUE: begin
        if (abort) begin
          state_next = FINISH;
          result     = RES_ABORT;
        end else begin
          state_next = WAIT_SENT;
        end
      end
      WAIT_SENT: begin
        if (abort) begin
          state_next = FINISH;
          result     = RES_ABORT;
        end else if (cmd_sent) begin
          state_next = WAIT_RESP;
        end else if (tmo_hit) begin
          state_next = FINISH;
          result     = RES_TMO;
        end
      end
      WAIT_RESP: begin
        if (abort) begin
          state_next = FINISH;
          result     = RES_ABORT;
        end else if (resp_rdy) begin
          if (resp != ACK) begin
            state_next = FINISH;
            result     = RES_RESP;
          end else if (last_cmd) begin
            state_next = FINISH;
            result     = RES_PASS;
          end else begin
            state_next = ISSUE;
            idx_next   = idx + 1'b1;
          end
        end else if (tmo_hit) begin
          state_next = FINISH;
          result     = RES_TMO;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      timer    <= '0;
      cmd      <= 16'h0000;
      count    <= '0;
      pass     <= 1'b0;
      tmo_err  <= 1'b0;
      resp_err <= 1'b0;
      fail_idx <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;

      if (state_next == ISSUE)
        cmd <= mem[idx_next];

      if (state == ISSUE)
        timer <= '0;
      else if (state == WAIT_SENT || state == WAIT_RESP)
        timer <= timer + 1'b1;

      if (clr_go)
        count <= '0;
      else if (load_go)
        count <= count + 1'b1;

      if (clr_go) begin
        pass     <= 1'b0;
        tmo_err  <= 1'b0;
        resp_err <= 1'b0;
        fail_idx <= '0;
      end else if (start_go) begin
        pass     <= (count == '0);
        tmo_err  <= 1'b0;
        resp_err <= 1'b0;
        fail_idx <= '0;
      end else begin
        unique case (result)
          RES_PASS:  pass <= 1'b1;
          RES_TMO:   begin tmo_err  <= 1'b1; fail_idx <= idx; end
          RES_RESP:  begin resp_err <= 1'b1; fail_idx <= idx; end
          RES_ABORT: fail_idx <= idx;
          default:   ;
        endcase
      end
    end
  end

  // NOTE: the command array is deliberately not reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (load_go)
      mem[count[AW-1:0]] <= load_cmd;
  end

endmodule

// File: doc/cmd_sequencer.md
# cmd_sequencer

Replays a buffered list of 16-bit Knight's Tour commands through RemoteComm, one at a time, without any testbench involvement. After each command it waits for `cmd_sent`, then for the response byte, with a watchdog timeout. It checks each response against the expected acknowledge byte and reports pass/fail with the index of the first failing command. It sits between a host/stimulus source and RemoteComm (`cmd`/`send_cmd`/`cmd_sent`/`resp_rdy`/`resp`), generalising the single-command "send then wait" flow to a parametrised-depth scripted sequence.

## Interface
- `DEPTH`, 16: command buffer entries; power of two, ≥2.
- `TMO_W`, 24: width of the watchdog counter.
- `TIMEOUT`, 10_000_000: cycles allowed from `send_cmd` to `resp_rdy`; must be < 2^TMO_W.
- `ACK`, 8'hA5: expected response byte.
- `clk` in 1: system clock, all state on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `load` in 1: write `load_cmd` into the next buffer entry.
- `load_cmd` in 16: command word to buffer.
- `start` in 1: begin replaying buffered commands from entry 0.
- `abort` in 1: stop the sequence and finish with fail.
- `clr` in 1: empty the buffer and clear status.
- `cmd` out 16: command presented to RemoteComm.
- `send_cmd` out 1: one-cycle request to RemoteComm.
- `cmd_sent` in 1: RemoteComm finished transmitting `cmd`.
- `resp_rdy` in 1: response byte valid (pulse).
- `resp` in 8: response byte.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle pulse when the sequence ends.
- `pass` out 1: last sequence completed with all ACKs; held until the next `start`/`clr`.
- `tmo_err` out 1: last sequence ended on timeout; held.
- `resp_err` out 1: last sequence ended on a non-ACK response; held.
- `fail_idx` out $clog2(DEPTH): index of the failing command; held.
- `count` out $clog2(DEPTH)+1: number of buffered commands.
- `full` out 1: `count == DEPTH`.

## Operation
- Buffer: `DEPTH`×16 array with write pointer.
  - `load` when `!busy && !full` stores at `count` and increments `count`.
  - `load` when full or busy is ignored.
  - `clr` (only honoured when `!busy`) zeroes `count`, `pass`, `tmo_err`, `resp_err`, `fail_idx`.
- States: IDLE, ISSUE, WAIT_SENT, WAIT_RESP, FINISH.
- IDLE:
  - `start` with `count==0` → FINISH with `pass=1`.
  - `start` with `count>0` → clear flags, `idx=0`, go to ISSUE.
- ISSUE:
  - Drive `cmd=buf[idx]` and `send_cmd=1` for exactly this cycle.
  - Clear timer; go to WAIT_SENT.
- WAIT_SENT: on `cmd_sent` → WAIT_RESP.
- WAIT_RESP: on `resp_rdy`:
  - `resp==ACK` and `idx==count-1` → FINISH, `pass=1`.
  - `resp==ACK` otherwise → `idx+1`, go to ISSUE.
  - `resp!=ACK` → FINISH, `resp_err=1`, `fail_idx=idx`.
- Timeout: the timer increments every cycle in WAIT_SENT and WAIT_RESP. When it reaches `TIMEOUT` with no qualifying event, go to FINISH with `tmo_err=1`, `fail_idx=idx`.
- `resp_rdy` arriving in WAIT_SENT (no `cmd_sent` yet) is ignored.
- `abort` in any non-IDLE state → FINISH with `tmo_err=0`, `resp_err=0`, `pass=0`, `fail_idx=idx`. `abort` has priority over all other events that cycle.
- FINISH: `done=1` for one cycle → IDLE. The buffer contents are preserved, so `start` replays the same list.
- `start`, `load` and `clr` are ignored while `busy`.

## Timing
- Reset values:
  - `cmd=16'h0000`, `send_cmd=0`, `busy=0`, `done=0`.
  - `pass=0`, `tmo_err=0`, `resp_err=0`, `fail_idx=0`, `count=0`, `full=0`.
  - State is IDLE.
- `busy` rises the cycle after `start` and falls the cycle after `done`.
- `send_cmd` asserts 1 cycle after `start` or after the accepted `resp_rdy`.
- `cmd` is registered; it changes only on entry to ISSUE and holds until the next ISSUE.
- The event and the timeout terminal count in the same cycle: the event wins.
- The timeout counts exactly `TIMEOUT` cycles after the ISSUE cycle.
- `done` asserts 1 cycle after the terminating event. Result flags are valid in the same cycle as `done`.
- Reset mid-sequence: immediate return to reset values. The buffer count is lost.

## Test plan
- Load 4 commands (0x2001, 0x2042, 0x3081, 0x30C2). `start`; model returns `cmd_sent` then `resp=A5` each time → 4 `send_cmd` pulses in order, `done` once, `pass=1`, `fail_idx=0`.
- Same 4 commands; third response is 0x5A → exactly 3 `send_cmd` pulses, `resp_err=1`, `fail_idx=2`, `pass=0`.
- `TIMEOUT=100`; model never asserts `resp_rdy` on command 1 → `done` exactly 101 cycles after that `send_cmd`, `tmo_err=1`, `fail_idx=1`.
- Load 18 commands with `DEPTH=16` → `full=1`, `count=16`, last two ignored. `start` with empty buffer after `clr` → `done` next cycle, `pass=1`, no `send_cmd`.
- `abort` during WAIT_RESP of command 0 → `done`, all flags 0, `fail_idx=0`. `load` during `busy` leaves `count` unchanged.
- Assert `rst_n` low mid-WAIT_RESP → all outputs at reset values asynchronously. `resp_rdy` and the timeout terminal count in the same cycle → `pass` path taken.
